// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBrkWait
    } rx_state_t;

    localparam logic UartIdleLvl = 1'b1;

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side bus: oversample tick and serial line in, recovered word and status out.
interface uart_rx_if #(
    parameter int unsigned DataBits = 8
);
    logic                sample_tick;
    logic                rx_serial;
    logic [DataBits-1:0] rx_data;
    logic                data_rdy;
    logic                parity_err;
    logic                frame_err;
    logic                busy;

    modport master (
        output sample_tick, rx_serial,
        input  rx_data, data_rdy, parity_err, frame_err, busy
    );

    modport slave (
        input  sample_tick, rx_serial,
        output rx_data, data_rdy, parity_err, frame_err, busy
    );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous input, with selectable reset level.
module uart_rx_sync #(
    parameter logic ResetVal = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q, sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= ResetVal;
            sync_q <= ResetVal;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/parity/stop recovery with parity and framing flags.
module uart_rx #(
    parameter int unsigned DataBits   = 8,
    parameter int unsigned Oversample = 16,
    parameter bit          ParityEn   = 1'b0,
    parameter bit          ParityOdd  = 1'b0
) (
    input logic     clk,
    input logic     rst,
    uart_rx_if.slave bus_io
);
    import uart_rx_pkg::*;

    localparam int unsigned TickW = $clog2(Oversample);
    localparam int unsigned BitW  = $clog2(DataBits + 1);
    localparam logic [TickW-1:0] HalfM1 = TickW'(Oversample / 2 - 1);
    localparam logic [TickW-1:0] FullM1 = TickW'(Oversample - 1);
    localparam logic [BitW-1:0]  LastBit = BitW'(DataBits - 1);

    rx_state_t           state_q, state_d;
    logic [TickW-1:0]    tick_cnt_q, tick_cnt_d;
    logic [BitW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DataBits-1:0] shreg_q, shreg_d;
    logic [DataBits-1:0] rx_data_q, rx_data_d;
    logic                perr_q, perr_d;
    logic                data_rdy_q, data_rdy_d;
    logic                parity_err_q, parity_err_d;
    logic                frame_err_q, frame_err_d;
    logic                busy_q, busy_d;
    logic                rx_s;

    uart_rx_sync #(
        .ResetVal (UartIdleLvl)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (bus_io.rx_serial),
        .q_o (rx_s)
    );

    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        rx_data_d    = rx_data_q;
        perr_d       = perr_q;
        data_rdy_d   = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        if (bus_io.sample_tick) begin
            unique case (state_q)
                StIdle: begin
                    if (!rx_s) begin
                        state_d    = StStart;
                        tick_cnt_d = '0;
                    end
                end
                StStart: begin
                    if (tick_cnt_q == HalfM1) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = rx_s ? StIdle : StData;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TickW'(1);
                    end
                end
                StData: begin
                    // Counting restarts at each bit centre, so later samples stay centred.
                    if (tick_cnt_q == FullM1) begin
                        tick_cnt_d = '0;
                        shreg_d    = {rx_s, shreg_q[DataBits-1:1]};
                        bit_cnt_d  = bit_cnt_q + BitW'(1);
                        if (bit_cnt_q == LastBit) state_d = ParityEn ? StParity : StStop;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TickW'(1);
                    end
                end
                StParity: begin
                    if (tick_cnt_q == FullM1) begin
                        tick_cnt_d = '0;
                        perr_d     = ^shreg_q ^ rx_s ^ ParityOdd;
                        state_d    = StStop;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TickW'(1);
                    end
                end
                StStop: begin
                    if (tick_cnt_q == FullM1) begin
                        tick_cnt_d   = '0;
                        parity_err_d = perr_q;
                        if (rx_s) begin
                            rx_data_d   = shreg_q;
                            data_rdy_d  = 1'b1;
                            frame_err_d = 1'b0;
                            state_d     = StIdle;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = StBrkWait;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TickW'(1);
                    end
                end
                StBrkWait: begin
                    if (rx_s) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            rx_data_q    <= '0;
            perr_q       <= 1'b0;
            data_rdy_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            rx_data_q    <= rx_data_d;
            perr_q       <= perr_d;
            data_rdy_q   <= data_rdy_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
        end
    end

    assign bus_io.rx_data    = rx_data_q;
    assign bus_io.data_rdy   = data_rdy_q;
    assign bus_io.parity_err = parity_err_q;
    assign bus_io.frame_err  = frame_err_q;
    assign bus_io.busy       = busy_q;

endmodule
